// File: rtl/dmem_pkg.sv
// Shared definitions for the M-stage data-memory access controller.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (see dmem_access_ctrl).
package dmem_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;

  // Access controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // funct3 encodings shared by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size decode
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Map funct3 to access size; unknown encodings are treated as a full word
  function automatic size_e decode_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: decode_size = SZ_B;
      F3_H, F3_HU: decode_size = SZ_H;
      F3_W:        decode_size = SZ_W;
      default:     decode_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: byte enables and store-data shift for the request,
// right-justifying shift for the returned load data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NBYTES     = BYTES,
  parameter int unsigned OFF_W      = 2
) (
  input  size_e                  req_size,
  input  logic [OFF_W-1:0]       req_offset,
  input  logic [DATA_WIDTH-1:0]  wdata_in,
  input  logic [OFF_W-1:0]       rsp_offset,
  input  logic [DATA_WIDTH-1:0]  rdata_in,
  output logic [NBYTES-1:0]      be_c,
  output logic [DATA_WIDTH-1:0]  wdata_c,
  output logic [DATA_WIDTH-1:0]  rdata_c
);

  logic [NBYTES-1:0] be_base;

  // Size-based enable mask shifted into place, data moved by 8*offset
  always_comb begin
    be_base = '0;
    case (req_size)
      SZ_B:    be_base = NBYTES'(1);
      SZ_H:    be_base = NBYTES'(3);
      default: be_base = '1;
    endcase
    be_c    = be_base << req_offset;
    wdata_c = wdata_in << {req_offset, 3'b000};
    rdata_c = rdata_in >> {rsp_offset, 3'b000};
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// M-stage data-memory access controller: load/store to word-aligned bus
// request with byte enables, pipeline stall until the response returns.
// Macro DMEM_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of
// silently aligning them down.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MemReadM,
  input  logic                    MemWriteM,
  input  logic [2:0]              LoadSrcM,
  input  logic [ADDR_WIDTH-1:0]   AddrM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  output logic                    BusReqValid,
  input  logic                    BusReqReady,
  output logic                    BusReqWrite,
  output logic [ADDR_WIDTH-1:0]   BusReqAddr,
  output logic [DATA_WIDTH/8-1:0] BusReqBe,
  output logic [DATA_WIDTH-1:0]   BusReqWData,
  input  logic                    BusRespValid,
  input  logic [DATA_WIDTH-1:0]   BusRespData,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic                    StallM,
  output logic                    MisalignedM
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);

  state_e                  state_q, state_d;
  logic                    valid_q, valid_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [NBYTES-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [OFF_W-1:0]        off_q, off_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  size_e                   size_c;
  logic [OFF_W-1:0]        off_c;
  logic                    misaligned_c;
  logic                    req_c;
  logic                    stall_c;
  logic                    mis_pulse_c;
  logic [NBYTES-1:0]       lane_be_c;
  logic [DATA_WIDTH-1:0]   lane_wdata_c;
  logic [DATA_WIDTH-1:0]   lane_rdata_c;

  assign req_c = MemReadM | MemWriteM;

  // Size decode, offset alignment and misalignment detection
  always_comb begin
    size_c       = decode_size(LoadSrcM);
    off_c        = AddrM[OFF_W-1:0];
    misaligned_c = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (size_c == SZ_H) begin
      misaligned_c = off_c[0];
    end else if (size_c == SZ_W) begin
      misaligned_c = |off_c;
    end
`else
    if (size_c == SZ_W) begin
      off_c = '0;
    end else if (size_c == SZ_H) begin
      off_c[0] = 1'b0;
    end
`endif
  end

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .NBYTES     (NBYTES),
    .OFF_W      (OFF_W)
  ) u_lane_align (
    .req_size   (size_c),
    .req_offset (off_c),
    .wdata_in   (WriteDataM),
    .rsp_offset (off_q),
    .rdata_in   (BusRespData),
    .be_c       (lane_be_c),
    .wdata_c    (lane_wdata_c),
    .rdata_c    (lane_rdata_c)
  );

  // Next-state and request/response bookkeeping
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    stall_c     = 1'b0;
    mis_pulse_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (misaligned_c) begin
            mis_pulse_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            write_d = MemWriteM;
            addr_d  = {AddrM[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            be_d    = lane_be_c;
            wdata_d = lane_wdata_c;
            off_d   = off_c;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (BusReqReady) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall_c = 1'b1;
        if (BusRespValid) begin
          if (!write_q) begin
            rdata_d = lane_rdata_c;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    valid_d = (state_d == ST_REQ);
  end

  // State and registered bus/read-data outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  assign BusReqValid = valid_q;
  assign BusReqWrite = write_q;
  assign BusReqAddr  = addr_q;
  assign BusReqBe    = be_q;
  assign BusReqWData = wdata_q;
  assign ReadDataM   = rdata_q;
  // Combinational stall/trap are forced low while reset is asserted
  assign StallM      = stall_c & rst_n;
  assign MisalignedM = mis_pulse_c & rst_n;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl; honours DMEM_MISALIGN_TRAP_EN.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  LoadSrcM;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic        BusReqValid;
  logic        BusReqReady;
  logic        BusReqWrite;
  logic [31:0] BusReqAddr;
  logic [3:0]  BusReqBe;
  logic [31:0] BusReqWData;
  logic        BusRespValid;
  logic [31:0] BusRespData;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignedM;

  int n_tests = 0;
  int n_fail  = 0;

  // Observations recorded by the access driver
  int          stall_cnt;
  int          valid_cnt;
  bit          unstable;
  bit          mis_seen;
  bit          timed_out;
  logic        stall_done;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] rdata_done;

  dmem_access_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .LoadSrcM     (LoadSrcM),
    .AddrM        (AddrM),
    .WriteDataM   (WriteDataM),
    .BusReqValid  (BusReqValid),
    .BusReqReady  (BusReqReady),
    .BusReqWrite  (BusReqWrite),
    .BusReqAddr   (BusReqAddr),
    .BusReqBe     (BusReqBe),
    .BusReqWData  (BusReqWData),
    .BusRespValid (BusRespValid),
    .BusRespData  (BusRespData),
    .ReadDataM    (ReadDataM),
    .StallM       (StallM),
    .MisalignedM  (MisalignedM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access from the M stage; inputs change at negedge, outputs sampled 1ns later.
  // rdy_delay = REQ cycles with ready low, rsp_delay = WAIT cycles without response.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rsp, input int rdy_delay, input int rsp_delay);
    int rdy_cnt = 0;
    int rsp_cnt = 0;
    bit in_wait = 0;
    bit resp_sent = 0;
    bit done = 0;
    stall_cnt = 0; valid_cnt = 0; unstable = 0; mis_seen = 0; timed_out = 0;
    stall_done = 1'bx; rdata_done = 'x;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; LoadSrcM = f3; AddrM = addr; WriteDataM = wd;
    BusRespData = rsp; BusReqReady = 0; BusRespValid = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      BusReqReady = 0;
      BusRespValid = 0;
      if (MisalignedM) mis_seen = 1;
      if (resp_sent) begin
        stall_done = StallM;
        rdata_done = ReadDataM;
        done = 1;
      end else begin
        if (StallM) stall_cnt++;
        if (BusReqValid) begin
          if (valid_cnt == 0) begin
            req_write = BusReqWrite; req_addr = BusReqAddr;
            req_be = BusReqBe; req_wdata = BusReqWData;
          end else if (req_write !== BusReqWrite || req_addr !== BusReqAddr ||
                       req_be !== BusReqBe || req_wdata !== BusReqWData) begin
            unstable = 1;
          end
          valid_cnt++;
          if (rdy_cnt == rdy_delay) BusReqReady = 1;
          rdy_cnt++;
        end else if (in_wait) begin
          if (rsp_cnt == rsp_delay) begin
            BusRespValid = 1;
            resp_sent = 1;
          end
          rsp_cnt++;
        end
        if (BusReqReady) in_wait = 1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) timed_out = 1;
    MemReadM = 0; MemWriteM = 0; BusReqReady = 0; BusRespValid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; MemReadM = 0; MemWriteM = 0; LoadSrcM = 3'b010; AddrM = 0;
    WriteDataM = 0; BusReqReady = 0; BusRespValid = 0; BusRespData = 0;
    #3;
    n_tests++;
    if ({BusReqValid, BusReqWrite, StallM, MisalignedM} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=0000", {BusReqValid, BusReqWrite, StallM, MisalignedM});
    end
    n_tests++;
    if ({BusReqAddr, BusReqBe, BusReqWData, ReadDataM} !== 100'd0) begin
      n_fail++; $display("FAIL reset_data got addr=%h be=%b wd=%h rd=%h exp all 0",
                         BusReqAddr, BusReqBe, BusReqWData, ReadDataM);
    end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_lw();
    run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL lw_timeout got=timeout exp=DONE"); end
    n_tests++;
    if (req_be !== 4'b1111 || req_addr !== 32'h100 || req_write !== 1'b0) begin
      n_fail++; $display("FAIL lw_req got be=%b addr=%h wr=%b exp be=1111 addr=00000100 wr=0", req_be, req_addr, req_write);
    end
    n_tests++;
    if (rdata_done !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got=%h exp=deadbeef", rdata_done); end
    n_tests++;
    if (stall_cnt != 3 || stall_done !== 1'b0) begin
      n_fail++; $display("FAIL lw_stall got cycles=%0d done_stall=%b exp cycles=3 done_stall=0", stall_cnt, stall_done);
    end
    #1;
    n_tests++;
    if (StallM !== 1'b0 || BusReqValid !== 1'b0) begin
      n_fail++; $display("FAIL lw_idle got stall=%b valid=%b exp 0 0", StallM, BusReqValid);
    end
  endtask

  task automatic test_lb();
    logic [2:0]  f3 [2];
    logic [31:0] ad [2];
    logic [3:0]  be [2];
    logic [31:0] rd [2];
    f3[0] = 3'b000; ad[0] = 32'h103; be[0] = 4'b1000; rd[0] = 32'h00000080;
    f3[1] = 3'b101; ad[1] = 32'h102; be[1] = 4'b1100; rd[1] = 32'h00008011;
    for (int i = 0; i < 2; i++) begin
      run_access(1, 0, f3[i], ad[i], 32'h0, 32'h80112233, 0, 0);
      n_tests++;
      if (req_addr !== 32'h100 || req_be !== be[i] || timed_out) begin
        n_fail++; $display("FAIL lb_req[%0d] got addr=%h be=%b to=%0d exp addr=00000100 be=%b", i, req_addr, req_be, timed_out, be[i]);
      end
      n_tests++;
      if (rdata_done !== rd[i]) begin n_fail++; $display("FAIL lb_rdata[%0d] got=%h exp=%h", i, rdata_done, rd[i]); end
    end
  endtask

  task automatic test_sh();
    run_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 0, 0);
    n_tests++;
    if (req_be !== 4'b1100 || req_addr !== 32'h200 || req_write !== 1'b1 || timed_out) begin
      n_fail++; $display("FAIL sh_req got be=%b addr=%h wr=%b exp be=1100 addr=00000200 wr=1", req_be, req_addr, req_write);
    end
    n_tests++;
    if (req_wdata !== 32'hABCD0000) begin n_fail++; $display("FAIL sh_wdata got=%h exp=abcd0000", req_wdata); end
    n_tests++;
    if (rdata_done !== 32'h00008011) begin n_fail++; $display("FAIL sh_rdata_hold got=%h exp=00008011", rdata_done); end
  endtask

  // Ready low through accept + 2 REQ cycles (3 cycles), response 2 cycles late
  task automatic test_back_to_back_stall();
    run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h12345678, 2, 2);
    n_tests++;
    if (stall_cnt != 7 || stall_done !== 1'b0 || timed_out) begin
      n_fail++; $display("FAIL bp_stall got cycles=%0d done_stall=%b exp cycles=7 done_stall=0", stall_cnt, stall_done);
    end
    n_tests++;
    if (valid_cnt != 3 || unstable) begin
      n_fail++; $display("FAIL bp_valid got cycles=%0d unstable=%0d exp cycles=3 unstable=0", valid_cnt, unstable);
    end
    n_tests++;
    if (rdata_done !== 32'h12345678 || req_addr !== 32'h300) begin
      n_fail++; $display("FAIL bp_data got rd=%h addr=%h exp rd=12345678 addr=00000300", rdata_done, req_addr);
    end
  endtask

  task automatic test_misalign();
`ifdef DMEM_MISALIGN_TRAP_EN
    @(negedge clk);
    MemReadM = 1; LoadSrcM = 3'b001; AddrM = 32'h101;
    #1;
    n_tests++;
    if (MisalignedM !== 1'b1 || StallM !== 1'b0) begin
      n_fail++; $display("FAIL mis_pulse got mis=%b stall=%b exp mis=1 stall=0", MisalignedM, StallM);
    end
    @(negedge clk);
    MemReadM = 0;
    #1;
    n_tests++;
    if (BusReqValid !== 1'b0 || MisalignedM !== 1'b0 || StallM !== 1'b0) begin
      n_fail++; $display("FAIL mis_after got valid=%b mis=%b stall=%b exp 0 0 0", BusReqValid, MisalignedM, StallM);
    end
`else
    run_access(1, 0, 3'b001, 32'h101, 32'h0, 32'hAABBCCDD, 0, 0);
    n_tests++;
    if (req_be !== 4'b0011 || req_addr !== 32'h100 || timed_out) begin
      n_fail++; $display("FAIL mis_align got be=%b addr=%h exp be=0011 addr=00000100", req_be, req_addr);
    end
    n_tests++;
    if (mis_seen || rdata_done !== 32'hAABBCCDD) begin
      n_fail++; $display("FAIL mis_data got mis=%0d rd=%h exp mis=0 rd=aabbccdd", mis_seen, rdata_done);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemReadM = 1; LoadSrcM = 3'b010; AddrM = 32'h400;
    @(negedge clk);
    #1;
    n_tests++;
    if (BusReqValid !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got valid=%b exp 1", BusReqValid); end
    BusReqReady = 1;
    @(negedge clk);
    BusReqReady = 0;
    #1;
    n_tests++;
    if (StallM !== 1'b1 || BusReqValid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_wait got stall=%b valid=%b exp 1 0", StallM, BusReqValid);
    end
    #1 rst_n = 0;
    #1;
    n_tests++;
    if ({BusReqValid, BusReqWrite, StallM, MisalignedM} !== 4'b0000 ||
        {BusReqAddr, BusReqBe, BusReqWData, ReadDataM} !== 100'd0) begin
      n_fail++; $display("FAIL rstmid_outs got v=%b w=%b s=%b m=%b a=%h be=%b wd=%h rd=%h exp all 0",
                         BusReqValid, BusReqWrite, StallM, MisalignedM, BusReqAddr, BusReqBe, BusReqWData, ReadDataM);
    end
    @(negedge clk);
    rst_n = 1; MemReadM = 0; BusRespValid = 1; BusRespData = 32'h55555555;
    @(negedge clk);
    BusRespValid = 0;
    #1;
    n_tests++;
    if (ReadDataM !== 32'h0 || StallM !== 1'b0 || BusReqValid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_late got rd=%h stall=%b valid=%b exp rd=00000000 stall=0 valid=0", ReadDataM, StallM, BusReqValid);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb();
    test_sh();
    test_back_to_back_stall();
    test_misalign();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Memory-stage data-memory access controller for the pipelined RISC-V core. It takes load/store requests from the M stage, turns them into word-aligned bus transactions with byte enables over a valid/ready handshake, and stalls the pipeline until the response arrives. It returns `ReadDataM` with the addressed byte or halfword right-justified, ready for the downstream partial-word sign/zero-extension stage.

## Interface
- `DATA_WIDTH`, 32, data bus width; must be a multiple of 8.
- `ADDR_WIDTH`, 32, byte address width.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `MemReadM`  in  1  load in M stage.
- `MemWriteM`  in  1  store in M stage; never asserted together with `MemReadM`.
- `LoadSrcM`  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `AddrM`  in  ADDR_WIDTH  byte address (ALU result).
- `WriteDataM`  in  DATA_WIDTH  store data, right-justified.
- `BusReqValid`  out  1  request valid.
- `BusReqReady`  in  1  bus accepts request.
- `BusReqWrite`  out  1  1 = write.
- `BusReqAddr`  out  ADDR_WIDTH  word-aligned address; low log2(DATA_WIDTH/8) bits are 0.
- `BusReqBe`  out  DATA_WIDTH/8  byte enables.
- `BusReqWData`  out  DATA_WIDTH  store data shifted into the selected lanes.
- `BusRespValid`  in  1  response (read data or write ack).
- `BusRespData`  in  DATA_WIDTH  read data.
- `ReadDataM`  out  DATA_WIDTH  load data shifted right by 8*offset.
- `StallM`  out  1  freezes the M stage and everything upstream of it.
- `MisalignedM`  out  1  misaligned access trap pulse.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when `MemReadM|MemWriteM` is high, `StallM`=1 combinationally. At the clock edge, latch the aligned address, byte enables, shifted write data, read/write flag and byte offset, then go to REQ.
- REQ: `BusReqValid`=1, with all request fields stable. Go to WAIT when `BusReqReady`=1. Stay in REQ otherwise.
- WAIT: wait for `BusRespValid`. For a read, capture `BusRespData >> (8*offset)` into `ReadDataM`. Go to DONE.
- DONE: `StallM`=0 for one cycle so the instruction retires. Always return to IDLE next, so the same instruction is never re-accepted.
- `StallM`=1 in IDLE (when a request is present), REQ and WAIT.
- Byte enables by size, shifted left by offset:
  - B = 0001.
  - H = 0011.
  - W = all ones.
- Write data: `WriteDataM << (8*offset)`.
- `ReadDataM` holds its value until the next read capture. Stores do not change it.
- `BusRespValid` outside WAIT is ignored.
- Reset, including mid-transaction: state goes to IDLE and all outputs go to 0. An outstanding bus response arriving after reset is dropped.

## Timing
- Zero-wait-state load or store: accept at cycle 0, REQ/ready at 1, response at 2, DONE at 3. `StallM` is high for cycles 0–2.
- A response is never expected in the same cycle as the request handshake.
- Each cycle that `BusReqReady` is low adds one cycle. Each cycle without `BusRespValid` in WAIT adds one cycle.
- `ReadDataM` is valid from the DONE cycle onward.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN`.
- Defined: an H access with odd offset, or a W access with nonzero offset, issues no bus request. `MisalignedM` pulses for one cycle in IDLE with `StallM`=0, and the FSM stays in IDLE.
- Undefined: `MisalignedM` is tied to 0. The offset is forced to 0 for W and bit 0 is cleared for H, i.e. the access is silently aligned down.

## Structure
- Shared package `dmem_pkg`:
  - FSM state enum.
  - funct3 load/store encodings.
  - Size decode constants.
  - `BYTES = DATA_WIDTH/8`.
- One sub-module, `dmem_lane_align`: combinational byte-enable, write-data shift and read-data shift from size and offset.

## Test plan
- LW at 0x100 with ready and response immediate, `BusRespData`=0xDEADBEEF → `BusReqBe`=1111, `ReadDataM`=0xDEADBEEF in cycle 3, `StallM` high for 3 cycles.
- LB at 0x103, `BusRespData`=0x80112233 → `BusReqAddr`=0x100, `BusReqBe`=1000, `ReadDataM`=0x00000080.
- SH at 0x202, `WriteDataM`=0x0000ABCD → `BusReqBe`=1100, `BusReqWData`=0xABCD0000, `ReadDataM` unchanged.
- `BusReqReady` held low 3 cycles, then response delayed 2 cycles → `BusReqValid` and fields stable throughout, `StallM` high for 7 cycles.
- LH at 0x101 → with `DMEM_MISALIGN_TRAP_EN`: `MisalignedM`=1 for one cycle, no `BusReqValid`. Without it: `BusReqBe`=0011 at address 0x100.
- `rst_n` low during WAIT → all outputs 0 asynchronously. A late `BusRespValid` after reset leaves `ReadDataM`=0.
